// File: rtl/systolic_edge_feeder_pkg.sv
// Shared constants and FSM state encoding for the systolic-array edge feeder.
package systolic_edge_feeder_pkg;

   localparam int unsigned FEEDER_DATA_WIDTH = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_FEED  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      CLEAR = ST_CLEAR,
      FEED  = ST_FEED,
      DRAIN = ST_DRAIN,
      DONE  = ST_DONE
   } feeder_state_e;

endpackage

// File: rtl/systolic_edge_feeder_lane_fifo.sv
// Per-lane synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module lane_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_async_n_i,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      cnt_r;
   logic                  push_s;
   logic                  pop_s;

   assign empty   = (cnt_r == {CNT_W{1'b0}});
   assign full    = (cnt_r == CNT_FULL);
   assign push_s  = push && !full;
   assign pop_s   = pop && !empty;
   assign rd_data = mem_r[rd_ptr_r];

   // Storage array; contents are only meaningful below cnt_r, so no reset.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CNT_W'(1);
            2'b01:   cnt_r <= cnt_r - CNT_W'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/systolic_edge_feeder.sv
// Fans tile-buffer beats out to N_LANES independent PE edge streams and sequences one tile.
// Optional diagonal start-up wavefront when SYSTOLIC_FEEDER_SKEW_EN is defined.
module systolic_edge_feeder
   import systolic_edge_feeder_pkg::*;
#(
   parameter int unsigned N_LANES         = 4,
   parameter int unsigned DATA_WIDTH      = FEEDER_DATA_WIDTH,
   parameter int unsigned LANE_FIFO_DEPTH = 4,
   parameter int unsigned K_WIDTH         = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_async_n_i,
   input  logic                          start_i,
   input  logic [K_WIDTH-1:0]            k_len_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          clear_acc_o,
   input  logic                          beat_valid_i,
   output logic                          beat_ready_o,
   input  logic [N_LANES*DATA_WIDTH-1:0] beat_data_i,
   output logic [N_LANES-1:0]            lane_valid_o,
   input  logic [N_LANES-1:0]            lane_ready_i,
   output logic [N_LANES*DATA_WIDTH-1:0] lane_data_o
);

   feeder_state_e        state_r;
   feeder_state_e        state_nxt_s;
   logic [K_WIDTH-1:0]   k_len_r;
   logic [K_WIDTH-1:0]   beat_cnt_r;
   logic [N_LANES-1:0]   empty_s;
   logic [N_LANES-1:0]   full_s;
   logic [N_LANES-1:0]   pop_s;
   logic [N_LANES-1:0]   skew_ok_s;
   logic [N_LANES-1:0]   lane_valid_s;
   logic                 pop_en_s;
   logic                 beat_ready_s;
   logic                 beat_fire_s;
   logic                 last_beat_s;

   assign pop_en_s     = (state_r == FEED) || (state_r == DRAIN);
   assign beat_ready_s = (state_r == FEED) && (beat_cnt_r < k_len_r) && !(|full_s);
   assign beat_fire_s  = beat_ready_s && beat_valid_i;
   assign last_beat_s  = beat_fire_s && ((beat_cnt_r + K_WIDTH'(1)) == k_len_r);

   assign busy_o       = (state_r != IDLE);
   assign done_o       = (state_r == DONE);
   assign clear_acc_o  = (state_r == CLEAR);
   assign beat_ready_o = beat_ready_s;
   assign lane_valid_o = lane_valid_s;

   // Tile sequencer next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_i) begin
               if (k_len_i != {K_WIDTH{1'b0}}) begin
                  state_nxt_s = CLEAR;
               end else begin
                  state_nxt_s = DONE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CLEAR: state_nxt_s = FEED;
         FEED: begin
            if (last_beat_s) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = FEED;
            end
         end
         DRAIN: begin
            if (&empty_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, latched tile length and beat counter (saturates since ready needs cnt < k_len).
   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) begin
         state_r    <= IDLE;
         k_len_r    <= {K_WIDTH{1'b0}};
         beat_cnt_r <= {K_WIDTH{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == IDLE) && start_i) begin
            k_len_r <= k_len_i;
         end
         if (state_r == CLEAR) begin
            beat_cnt_r <= {K_WIDTH{1'b0}};
         end else if (beat_fire_s) begin
            beat_cnt_r <= beat_cnt_r + K_WIDTH'(1);
         end
      end
   end

`ifdef SYSTOLIC_FEEDER_SKEW_EN
   localparam int unsigned SKEW_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam logic [SKEW_W-1:0] SKEW_MAX = SKEW_W'(N_LANES - 1);

   logic [SKEW_W-1:0] skew_cnt_r;
   logic              skew_run_r;

   // Wavefront counter: advances from the first cycle lane 0 can present, so lane i trails by i.
   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) begin
         skew_cnt_r <= {SKEW_W{1'b0}};
         skew_run_r <= 1'b0;
      end else if (state_r == CLEAR) begin
         skew_cnt_r <= {SKEW_W{1'b0}};
         skew_run_r <= 1'b0;
      end else begin
         if (beat_fire_s) begin
            skew_run_r <= 1'b1;
         end
         if (skew_run_r && (skew_cnt_r != SKEW_MAX)) begin
            skew_cnt_r <= skew_cnt_r + SKEW_W'(1);
         end
      end
   end
`endif

   for (genvar g = 0; g < N_LANES; g++) begin : g_lane
      logic [DATA_WIDTH-1:0] head_s;

`ifdef SYSTOLIC_FEEDER_SKEW_EN
      assign skew_ok_s[g] = (skew_cnt_r >= SKEW_W'(g));
`else
      assign skew_ok_s[g] = 1'b1;
`endif

      assign lane_valid_s[g] = !empty_s[g] && pop_en_s && skew_ok_s[g];
      assign pop_s[g]        = lane_valid_s[g] && lane_ready_i[g];
      assign lane_data_o[g*DATA_WIDTH +: DATA_WIDTH] =
         lane_valid_s[g] ? head_s : {DATA_WIDTH{1'b0}};

      lane_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (LANE_FIFO_DEPTH)
      ) u_fifo (
         .clk_i         (clk_i),
         .rst_async_n_i (rst_async_n_i),
         .push          (beat_fire_s),
         .pop           (pop_s[g]),
         .wr_data       (beat_data_i[g*DATA_WIDTH +: DATA_WIDTH]),
         .rd_data       (head_s),
         .empty         (empty_s[g]),
         .full          (full_s[g])
      );
   end

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Scoreboard bench for systolic_edge_feeder: driver pushes expected lane elements, monitor pops and compares.
module tb_systolic_edge_feeder;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int KW = 16;
`ifdef SYSTOLIC_FEEDER_SKEW_EN
   localparam bit SKEW = 1'b1;
`else
   localparam bit SKEW = 1'b0;
`endif

   logic            clk_i = 1'b0;
   logic            rst_async_n_i;
   logic            start_i;
   logic [KW-1:0]   k_len_i;
   logic            busy_o;
   logic            done_o;
   logic            clear_acc_o;
   logic            beat_valid_i;
   logic            beat_ready_o;
   logic [N*DW-1:0] beat_data_i;
   logic [N-1:0]    lane_valid_o;
   logic [N-1:0]    lane_ready_i;
   logic [N*DW-1:0] lane_data_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int clear_cnt = 0;
   int acc_cnt  = 0;
   int pop_cnt   [N];
   int first_cyc [N];
   logic [DW-1:0] exp_q [N][$];
   logic [31:0]   beats [8];

   systolic_edge_feeder dut (
      .clk_i         (clk_i),
      .rst_async_n_i (rst_async_n_i),
      .start_i       (start_i),
      .k_len_i       (k_len_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .clear_acc_o   (clear_acc_o),
      .beat_valid_i  (beat_valid_i),
      .beat_ready_o  (beat_ready_o),
      .beat_data_i   (beat_data_i),
      .lane_valid_o  (lane_valid_o),
      .lane_ready_i  (lane_ready_i),
      .lane_data_o   (lane_data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Monitor: counts pulses and handshakes, pops the scoreboard on every lane handshake.
   initial begin
      logic [N-1:0]  hold_v;
      logic [DW-1:0] hold_d [N];
      logic [DW-1:0] d;
      logic [DW-1:0] e;
      hold_v = '0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (!rst_async_n_i) begin
            hold_v = '0;
         end else begin
            if (done_o) done_cnt++;
            if (clear_acc_o) clear_cnt++;
            if (beat_valid_i && beat_ready_o) acc_cnt++;
            for (int i = 0; i < N; i++) begin
               d = lane_data_o[i*DW +: DW];
               if (lane_valid_o[i] && first_cyc[i] < 0) first_cyc[i] = cyc;
               if (hold_v[i]) begin
                  chk($sformatf("hold_valid_l%0d", i), int'(lane_valid_o[i]), 1);
                  chk($sformatf("hold_data_l%0d", i), int'(d), int'(hold_d[i]));
               end
               if (lane_valid_o[i] && lane_ready_i[i]) begin
                  pop_cnt[i]++;
                  if (exp_q[i].size() == 0) begin
                     chk($sformatf("unexpected_pop_l%0d", i), int'(d), -1);
                  end else begin
                     e = exp_q[i].pop_front();
                     chk($sformatf("lane_data_l%0d", i), int'(d), int'(e));
                  end
               end
               hold_v[i] = lane_valid_o[i] && !lane_ready_i[i];
               hold_d[i] = d;
            end
         end
      end
   end

   task automatic start_tile(input int k);
      @(posedge clk_i); #1;
      start_i = 1'b1;
      k_len_i = KW'(k);
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   // Driver: offers beats[idx..idx+n-1]; expected lane elements are queued on each handshake.
   task automatic feed(input int idx, input int n);
      for (int b = 0; b < n; b++) begin
         bit ok;
         ok = 1'b0;
         beat_valid_i = 1'b1;
         beat_data_i  = beats[idx + b];
         for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk_i);
            if (beat_ready_o) begin
               for (int i = 0; i < N; i++) exp_q[i].push_back(beats[idx + b][i*DW +: DW]);
               @(posedge clk_i); #1;
               ok = 1'b1;
            end
         end
         beat_valid_i = 1'b0;
         if (!ok) chk("beat_timeout", 0, 1);
      end
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 300 && !seen; t++) begin
         @(negedge clk_i);
         if (done_o) seen = 1'b1;
      end
      chk("done_seen", int'(seen), 1);
      chk("busy_at_done", int'(busy_o), 1);
      @(negedge clk_i);
      chk("done_one_cycle", int'(done_o), 0);
      chk("busy_after_done", int'(busy_o), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, c0, a0;
      int p0 [N];
      beats[0] = 32'h04030201; beats[1] = 32'h08070605;
      beats[2] = 32'h0C0B0A09; beats[3] = 32'h100F0E0D;
      beats[4] = 32'h14131211; beats[5] = 32'h18171615;
      beats[6] = 32'h1C1B1A19; beats[7] = 32'h201F1E1D;
      for (int i = 0; i < N; i++) begin pop_cnt[i] = 0; first_cyc[i] = -1; end
      rst_async_n_i = 1'b0; start_i = 1'b0; k_len_i = '0;
      beat_valid_i = 1'b0; beat_data_i = '0; lane_ready_i = '1;

      // Reset state
      repeat (3) @(negedge clk_i);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_done", int'(done_o), 0);
      chk("rst_clear", int'(clear_acc_o), 0);
      chk("rst_beat_ready", int'(beat_ready_o), 0);
      chk("rst_lane_valid", int'(lane_valid_o), 0);
      chk("rst_lane_data", int'(lane_data_o), 0);
      @(posedge clk_i); #1;
      rst_async_n_i = 1'b1;

      // Basic tile, k_len=3, no backpressure
      d0 = done_cnt; c0 = clear_cnt;
      start_tile(3);
      @(negedge clk_i);
      chk("basic_clear_acc", int'(clear_acc_o), 1);
      chk("basic_ready_in_clear", int'(beat_ready_o), 0);
      @(posedge clk_i); #1;
      feed(0, 3);
      wait_done();
      chk("basic_done_count", done_cnt - d0, 1);
      chk("basic_clear_count", clear_cnt - c0, 1);
      for (int i = 0; i < N; i++) chk($sformatf("basic_pops_l%0d", i), pop_cnt[i], 3);

      // k_len=0: straight to DONE
      d0 = done_cnt; c0 = clear_cnt;
      for (int i = 0; i < N; i++) p0[i] = pop_cnt[i];
      start_tile(0);
      @(negedge clk_i);
      chk("k0_done", int'(done_o), 1);
      chk("k0_clear", int'(clear_acc_o), 0);
      chk("k0_lane_valid", int'(lane_valid_o), 0);
      @(negedge clk_i);
      chk("k0_busy_after", int'(busy_o), 0);
      chk("k0_clear_count", clear_cnt - c0, 0);
      chk("k0_done_count", done_cnt - d0, 1);
      chk("k0_no_pops", pop_cnt[0] - p0[0], 0);

      // Single-lane stall on lane 2, k_len=8
      for (int i = 0; i < N; i++) p0[i] = pop_cnt[i];
      lane_ready_i = 4'b1011;
      start_tile(8);
      a0 = acc_cnt;
      fork
         begin
            @(posedge clk_i); #1;
            feed(0, 8);
         end
         begin
            repeat (11) @(negedge clk_i);
            chk("stall_beats_accepted", acc_cnt - a0, 4);
            chk("stall_beat_ready", int'(beat_ready_o), 0);
            chk("stall_l2_valid", int'(lane_valid_o[2]), 1);
            chk("stall_l2_data", int'(lane_data_o[2*DW +: DW]), 8'h03);
            chk("stall_pops_l0", pop_cnt[0] - p0[0], 4);
            chk("stall_pops_l1", pop_cnt[1] - p0[1], 4);
            chk("stall_pops_l2", pop_cnt[2] - p0[2], 0);
            chk("stall_pops_l3", pop_cnt[3] - p0[3], 4);
            @(posedge clk_i); #1;
            lane_ready_i = 4'hF;
         end
      join
      wait_done();
      for (int i = 0; i < N; i++) chk($sformatf("stall_total_l%0d", i), pop_cnt[i] - p0[i], 8);

      // Reset in the middle of FEED, then a clean k_len=2 tile
      lane_ready_i = 4'h0;
      start_tile(5);
      @(posedge clk_i); #1;
      feed(0, 2);
      d0 = done_cnt;
      rst_async_n_i = 1'b0;
      #1;
      chk("midrst_busy", int'(busy_o), 0);
      chk("midrst_beat_ready", int'(beat_ready_o), 0);
      chk("midrst_lane_valid", int'(lane_valid_o), 0);
      chk("midrst_lane_data", int'(lane_data_o), 0);
      for (int i = 0; i < N; i++) exp_q[i].delete();
      repeat (2) @(negedge clk_i);
      @(posedge clk_i); #1;
      rst_async_n_i = 1'b1;
      lane_ready_i = 4'hF;
      for (int i = 0; i < N; i++) p0[i] = pop_cnt[i];
      start_tile(2);
      @(posedge clk_i); #1;
      feed(4, 2);
      wait_done();
      chk("midrst_done_count", done_cnt - d0, 1);
      for (int i = 0; i < N; i++) chk($sformatf("midrst_pops_l%0d", i), pop_cnt[i] - p0[i], 2);

      // start_i while busy is ignored
      d0 = done_cnt;
      for (int i = 0; i < N; i++) p0[i] = pop_cnt[i];
      start_tile(3);
      start_i = 1'b1;
      k_len_i = KW'(7);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      feed(1, 3);
      wait_done();
      repeat (10) @(negedge clk_i);
      chk("busy_start_done_count", done_cnt - d0, 1);
      chk("busy_start_idle", int'(busy_o), 0);
      chk("busy_start_pops", pop_cnt[3] - p0[3], 3);

      // Start-up wavefront: lane i trails lane 0 by i cycles only with skew enabled
      for (int i = 0; i < N; i++) first_cyc[i] = -1;
      start_tile(2);
      @(posedge clk_i); #1;
      feed(2, 2);
      wait_done();
      for (int i = 1; i < N; i++)
         chk($sformatf("skew_offset_l%0d", i), first_cyc[i] - first_cyc[0], SKEW ? i : 0);
      for (int i = 0; i < N; i++) chk($sformatf("final_queue_empty_l%0d", i), exp_q[i].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
